// File: rtl/alu_7bit_pkg.sv
// Shared constants and operation encodings for the 7-bit NOT/SHR ALU.
package alu_7bit_pkg;

  localparam int unsigned WIDTH = 7;

  typedef enum logic {
    OP_NOT = 1'b0,
    OP_SHR = 1'b1
  } op_e;

  localparam logic [WIDTH-1:0] RESULT_RST    = '0;
  localparam logic             ZF_RST        = 1'b1;
  localparam logic             OUT_VALID_RST = 1'b0;

endpackage

// File: rtl/alu_7bit_shr.sv
// Combinational logical right shifter: 1/2/4 barrel stages plus saturation to zero.
module alu_7bit_shr #(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] s4;
  logic             sat;

  // Three barrel stages cover amounts 0..6; amounts of 7 and up force zero
  always_comb begin
    s1  = b[0] ? (a  >> 1) : a;
    s2  = b[1] ? (s1 >> 2) : s1;
    s4  = b[2] ? (s2 >> 4) : s2;
    sat = (|b[WIDTH-1:3]) || (b[2:0] == 3'b111);
    y   = sat ? '0 : s4;
  end

endmodule

// File: rtl/alu_7bit.sv
// Registered 7-bit ALU: NOT of A or logical right shift of A by B, with zero flag.
module alu_7bit
  import alu_7bit_pkg::*;
#(
  parameter int unsigned WIDTH = alu_7bit_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             OP,
  input  logic             in_valid,
  output logic [WIDTH-1:0] result,
  output logic             ZF,
  output logic             out_valid
);

  logic [WIDTH-1:0] shr_y;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH-1:0] result_d, result_q;
  logic             zf_d, zf_q;
  logic             out_valid_d, out_valid_q;

  alu_7bit_shr #(
    .WIDTH(WIDTH)
  ) u_shr (
    .a(A),
    .b(B),
    .y(shr_y)
  );

  // Operation mux, zero detect on the new value, and hold when no operation is issued
  always_comb begin
    result_d    = result_q;
    zf_d        = zf_q;
    out_valid_d = 1'b0;
    op_y        = (op_e'(OP) == OP_SHR) ? shr_y : ~A;
    if (in_valid) begin
      result_d    = op_y;
      zf_d        = (op_y == '0);
      out_valid_d = 1'b1;
    end
  end

  // Output registers; reset wins over a simultaneous in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= RESULT_RST;
      zf_q        <= ZF_RST;
      out_valid_q <= OUT_VALID_RST;
    end else begin
      result_q    <= result_d;
      zf_q        <= zf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign ZF        = zf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_7bit.sv
// Self-checking bench for alu_7bit: directed vector table, hold/reset sequences, random ops.
module tb_alu_7bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] A;
  logic [6:0] B;
  logic       OP;
  logic       in_valid;
  logic [6:0] result;
  logic       ZF;
  logic       out_valid;

  int checks   = 0;
  int failures = 0;

  alu_7bit #(.WIDTH(7)) dut (
    .clk(clk),
    .rst(rst),
    .A(A),
    .B(B),
    .OP(OP),
    .in_valid(in_valid),
    .result(result),
    .ZF(ZF),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [6:0] a;
    logic [6:0] b;
    logic       op;
    logic [6:0] exp_res;
    logic       exp_zf;
  } vec_t;

  // Reference behaviour straight from the operation rules
  function automatic logic [6:0] ref_op(input logic [6:0] a, input logic [6:0] b, input logic op);
    int unsigned amt;
    int unsigned val;
    if (op == 1'b0) return ~a;
    amt = b;
    if (amt >= 7) return 7'd0;
    val = a;
    val = val / (1 << amt);
    return val[6:0];
  endfunction

  task automatic drive(input logic v, input logic [6:0] a, input logic [6:0] b, input logic op);
    in_valid = v;
    A        = a;
    B        = b;
    OP       = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] er, input logic ez, input logic ev);
    checks++;
    if (result !== er || ZF !== ez || out_valid !== ev) begin
      failures++;
      $display("FAIL %s: got result=%b ZF=%b out_valid=%b, expected result=%b ZF=%b out_valid=%b",
               name, result, ZF, out_valid, er, ez, ev);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs[$];
    logic [6:0] m_res;
    logic       m_zf;
    logic       m_v;
    logic       rv, rr, ro;
    logic [6:0] ra, rb;

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    @(negedge clk);
    step();
    check("reset_state", 7'b0000000, 1'b1, 1'b0);
    rst = 1'b0;
    step();
    check("idle_after_reset", 7'b0000000, 1'b1, 1'b0);

    vecs.push_back('{"not_1010101",   7'b1010101, 7'd0,   1'b0, 7'b0101010, 1'b0});
    vecs.push_back('{"shr_b1",        7'b1100110, 7'd1,   1'b1, 7'b0110011, 1'b0});
    vecs.push_back('{"shr_b3",        7'b1100110, 7'd3,   1'b1, 7'b0001100, 1'b0});
    vecs.push_back('{"shr_b7_sat",    7'b1100110, 7'd7,   1'b1, 7'b0000000, 1'b1});
    vecs.push_back('{"shr_b127_sat",  7'b1100110, 7'd127, 1'b1, 7'b0000000, 1'b1});
    vecs.push_back('{"shr_b8_sat",    7'b1100110, 7'd8,   1'b1, 7'b0000000, 1'b1});
    vecs.push_back('{"not_zero_in",   7'b0000000, 7'd5,   1'b0, 7'b1111111, 1'b0});
    vecs.push_back('{"shr_to_zero",   7'b0000001, 7'd1,   1'b1, 7'b0000000, 1'b1});
    vecs.push_back('{"shr_b0",        7'b1010101, 7'd0,   1'b1, 7'b1010101, 1'b0});
    vecs.push_back('{"shr_b6",        7'b1000000, 7'd6,   1'b1, 7'b0000001, 1'b0});
    vecs.push_back('{"not_all_ones",  7'b1111111, 7'd0,   1'b0, 7'b0000000, 1'b1});
    vecs.push_back('{"shr_b2",        7'b1111111, 7'd2,   1'b1, 7'b0011111, 1'b0});
    vecs.push_back('{"shr_b15_sat",   7'b1111111, 7'd15,  1'b1, 7'b0000000, 1'b1});
    vecs.push_back('{"shr_b4",        7'b1110000, 7'd4,   1'b1, 7'b0000111, 1'b0});

    // Back-to-back: in_valid stays high across the whole table
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      step();
      check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_zf, 1'b1);
    end

    // Hold: last op left result=0000111 ZF=0; inputs toggle while in_valid=0
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 7'($urandom), 7'($urandom), 1'($urandom));
      step();
      check("hold_idle", 7'b0000111, 1'b0, 1'b0);
    end

    // Reset coincident with a valid NOT of zero: op is not performed
    drive(1'b1, 7'b0000000, 7'd0, 1'b0);
    rst = 1'b1;
    step();
    check("reset_beats_valid", 7'b0000000, 1'b1, 1'b0);
    rst = 1'b0;

    // Reset mid-stream discards the pending result
    drive(1'b1, 7'b0000001, 7'd0, 1'b0);
    step();
    check("pre_reset_op", 7'b1111110, 1'b0, 1'b1);
    drive(1'b1, 7'b0010000, 7'd1, 1'b1);
    rst = 1'b1;
    step();
    check("reset_midstream", 7'b0000000, 1'b1, 1'b0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    step();
    check("post_reset_idle", 7'b0000000, 1'b1, 1'b0);

    // Randomised operations against the reference model
    m_res = 7'd0;
    m_zf  = 1'b1;
    m_v   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 31) == 0);
      ro = 1'($urandom);
      ra = 7'($urandom);
      rb = ($urandom_range(0, 1) != 0) ? 7'($urandom_range(0, 9)) : 7'($urandom);
      drive(rv, ra, rb, ro);
      rst = rr;
      step();
      if (rr) begin
        m_res = 7'd0;
        m_zf  = 1'b1;
        m_v   = 1'b0;
      end else if (rv) begin
        m_res = ref_op(ra, rb, ro);
        m_zf  = (m_res == 7'd0);
        m_v   = 1'b1;
      end else begin
        m_v = 1'b0;
      end
      check("random", m_res, m_zf, m_v);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
